// File: rtl/fft_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fft_ctrl_pkg
// Shared constants and types for the radix-2 DIT FFT sequencer.
//   LOGN_DEF   : default log2 of the transform length (N = 32)
//   N_HALF_DEF : default butterflies per round (N/2)
//   OP_LAT_DEF : default butterfly pipeline latency in cycles
//   state_t    : sequencer state encoding
// ---------------------------------------------------------------------------
package fft_ctrl_pkg;

  localparam int LOGN_DEF   = 5;
  localparam int N_HALF_DEF = 1 << (LOGN_DEF - 1);
  localparam int OP_LAT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// ---------------------------------------------------------------------------
// fft_addr_gen
// Combinational butterfly address map for an in-place radix-2 DIT FFT.
// Ports:
//   i_rnd    in  RW      round number, 0..LOGN-1
//   i_iter   in  LOGN-1  butterfly index k within the round
//   o_addra  out LOGN    operand a address: grp*2*half + idx
//   o_addrb  out LOGN    operand b address: addra + half
//   o_tw_idx out LOGN-1  twiddle index: idx << (LOGN-1-rnd)
// ---------------------------------------------------------------------------
module fft_addr_gen
  import fft_ctrl_pkg::*;
#(
  parameter int LOGN = LOGN_DEF,
  parameter int RW   = (LOGN > 1) ? $clog2(LOGN) : 1
) (
  input  logic [RW-1:0]   i_rnd,
  input  logic [LOGN-2:0] i_iter,
  output logic [LOGN-1:0] o_addra,
  output logic [LOGN-1:0] o_addrb,
  output logic [LOGN-2:0] o_tw_idx
);

  logic [LOGN-1:0] w_half;
  logic [LOGN-1:0] w_iter;
  logic [LOGN-1:0] w_idx;
  logic [LOGN-1:0] w_grp;

  always_comb begin
    w_half   = LOGN'(1) << i_rnd;
    w_iter   = {1'b0, i_iter};
    w_idx    = w_iter & (w_half - LOGN'(1));
    w_grp    = w_iter >> i_rnd;
    // Group base is grp*2*half; idx < half so OR equals addition here.
    o_addra  = (w_grp << (int'(i_rnd) + 1)) | w_idx;
    // b < N always, so the LOGN-bit sum never wraps.
    o_addrb  = o_addra + w_half;
    // idx < 2^rnd, so the shifted value always fits in LOGN-1 bits.
    o_tw_idx = w_idx[LOGN-2:0] << (LOGN - 1 - int'(i_rnd));
  end

endmodule

// File: rtl/fft_ctrl.sv
// ---------------------------------------------------------------------------
// fft_ctrl
// Sequencer for an in-place radix-2 DIT FFT over a dual-port BRAM and one
// pipelined butterfly. Issues one butterfly per cycle for N/2 cycles per
// round, drains the butterfly pipeline for 1+OP_LAT cycles, and repeats for
// LOGN rounds. Write-back addresses are the read addresses delayed by
// 1+OP_LAT cycles.
// Optional build macro: FFT_CTRL_INV_EN adds inv (in) / tw_conj (out) for
// inverse transforms via twiddle conjugation.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   sig            start pulse (ignored unless idle)
//   inv            [FFT_CTRL_INV_EN] inverse request, sampled with sig
//   busy, done     transform in progress / one-cycle completion pulse
//   rnd,iter,cycle status counters (CW bits)
//   rd_en, addra, addrb, tw_idx   butterfly read issue
//   wr_en, waddra, waddrb         butterfly write-back
//   tw_conj        [FFT_CTRL_INV_EN] latched inv for the whole transform
// ---------------------------------------------------------------------------
module fft_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int LOGN   = LOGN_DEF,
  parameter int OP_LAT = OP_LAT_DEF,
  parameter int CW     = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sig,
`ifdef FFT_CTRL_INV_EN
  input  logic            inv,
  output logic            tw_conj,
`endif
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   rnd,
  output logic [CW-1:0]   iter,
  output logic [CW-1:0]   cycle,
  output logic            rd_en,
  output logic [LOGN-1:0] addra,
  output logic [LOGN-1:0] addrb,
  output logic [LOGN-2:0] tw_idx,
  output logic            wr_en,
  output logic [LOGN-1:0] waddra,
  output logic [LOGN-1:0] waddrb
);

  localparam int N_HALF = 1 << (LOGN - 1);
  localparam int RW     = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int PD     = 1 + OP_LAT;
  localparam int DW     = (PD > 2) ? $clog2(PD) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_rnd;
  logic [CW-1:0]   r_iter;
  logic [CW-1:0]   r_cycle;
  logic [DW-1:0]   r_drain;
  logic            w_last_iter;
  logic            w_last_rnd;
  logic            w_drain_end;
  logic [LOGN-1:0] w_addra;
  logic [LOGN-1:0] w_addrb;
  logic [LOGN-2:0] w_tw_idx;

  logic            r_pv [PD];
  logic [LOGN-1:0] r_pa [PD];
  logic [LOGN-1:0] r_pb [PD];

  assign w_last_iter = (r_iter == CW'(N_HALF - 1));
  assign w_last_rnd  = (r_rnd == CW'(LOGN - 1));
  assign w_drain_end = (r_drain == DW'(OP_LAT));

  // NOTE: state register uses non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the default assignment up front guarantees every path drives
  // w_state_nxt, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (sig) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (w_last_iter) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drain_end) w_state_nxt = w_last_rnd ? ST_DONE : ST_ISSUE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rnd   <= '0;
      r_iter  <= '0;
      r_cycle <= '0;
      r_drain <= '0;
    end else begin
      if (busy && r_cycle != '1) r_cycle <= r_cycle + CW'(1);
      case (r_state)
        ST_IDLE: if (sig) begin
          r_rnd   <= '0;
          r_iter  <= '0;
          r_cycle <= '0;
          r_drain <= '0;
        end
        ST_ISSUE: begin
          if (w_last_iter) r_drain <= '0;
          else             r_iter  <= r_iter + CW'(1);
        end
        ST_DRAIN: begin
          r_drain <= r_drain + DW'(1);
          if (w_drain_end && !w_last_rnd) begin
            r_rnd  <= r_rnd + CW'(1);
            r_iter <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FFT_CTRL_INV_EN
  logic r_tw_conj;
  always_ff @(posedge clk) begin
    if (rst)                         r_tw_conj <= 1'b0;
    else if (r_state == ST_IDLE && sig) r_tw_conj <= inv;
  end
  assign tw_conj = r_tw_conj;
`endif

  fft_addr_gen #(.LOGN(LOGN), .RW(RW)) u_addr_gen (
    .i_rnd    (r_rnd[RW-1:0]),
    .i_iter   (r_iter[LOGN-2:0]),
    .o_addra  (w_addra),
    .o_addrb  (w_addrb),
    .o_tw_idx (w_tw_idx)
  );

  // Addresses are forced to 0 outside ISSUE so idle outputs read as 0 and
  // invalid pipe entries carry zero addresses.
  assign rd_en  = (r_state == ST_ISSUE);
  assign addra  = rd_en ? w_addra  : '0;
  assign addrb  = rd_en ? w_addrb  : '0;
  assign tw_idx = rd_en ? w_tw_idx : '0;

  // NOTE: this delay line is a handful of flops, not a RAM, so resetting
  // every entry is cheap and keeps write addresses at 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PD; i++) begin
        r_pv[i] <= 1'b0;
        r_pa[i] <= '0;
        r_pb[i] <= '0;
      end
    end else begin
      r_pv[0] <= rd_en;
      r_pa[0] <= addra;
      r_pb[0] <= addrb;
      for (int i = 1; i < PD; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pb[i] <= r_pb[i-1];
      end
    end
  end

  assign wr_en  = r_pv[PD-1];
  assign waddra = r_pa[PD-1];
  assign waddrb = r_pb[PD-1];

  assign busy  = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign done  = (r_state == ST_DONE);
  assign rnd   = r_rnd;
  assign iter  = r_iter;
  assign cycle = r_cycle;

endmodule

// File: tb/tb_fft_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_ctrl
// Directed self-checking bench for fft_ctrl at LOGN=5, OP_LAT=4, CW=17.
// Build with FFT_CTRL_INV_EN defined to exercise inv/tw_conj.
// ---------------------------------------------------------------------------
module tb_fft_ctrl;
  import fft_ctrl_pkg::*;

  localparam int LOGN      = 5;
  localparam int CW        = 17;
  localparam int ISSUE_CYC = N_HALF_DEF;       // 16
  localparam int ROUND_CYC = ISSUE_CYC + 5;    // 21
  localparam int BUSY_CYC  = 5 * ROUND_CYC;    // 105

  logic            clk = 1'b0;
  logic            rst;
  logic            sig;
  logic            busy, done, rd_en, wr_en;
  logic [CW-1:0]   rnd, iter, cycle;
  logic [LOGN-1:0] addra, addrb, waddra, waddrb;
  logic [LOGN-2:0] tw_idx;
`ifdef FFT_CTRL_INV_EN
  logic            inv;
  logic            tw_conj;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int hist_a [0:255];
  int hist_b [0:255];

  always #5 clk = ~clk;

  fft_ctrl #(.LOGN(LOGN), .OP_LAT(4), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .sig    (sig),
`ifdef FFT_CTRL_INV_EN
    .inv    (inv),
    .tw_conj(tw_conj),
`endif
    .busy   (busy),
    .done   (done),
    .rnd    (rnd),
    .iter   (iter),
    .cycle  (cycle),
    .rd_en  (rd_en),
    .addra  (addra),
    .addrb  (addrb),
    .tw_idx (tw_idx),
    .wr_en  (wr_en),
    .waddra (waddra),
    .waddrb (waddrb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference address map written with division/modulo.
  function automatic void ref_addr(input int r, input int k, output int a, output int b, output int tw);
    int half;
    half = 1 << r;
    a    = (k / half) * (2 * half) + (k % half);
    b    = a + half;
    tw   = (k % half) * (16 / half);
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  busy,   0);
    check({tag, "_done"},  done,   0);
    check({tag, "_rd_en"}, rd_en,  0);
    check({tag, "_wr_en"}, wr_en,  0);
    check({tag, "_addra"}, addra,  0);
    check({tag, "_addrb"}, addrb,  0);
    check({tag, "_tw"},    tw_idx, 0);
    check({tag, "_waddra"}, waddra, 0);
    check({tag, "_waddrb"}, waddrb, 0);
  endtask

  // Full transform with per-cycle expectations. When 'pulses' is set, extra
  // sig pulses land mid-run and in the DONE cycle, and (inverse build) inv=1.
  task automatic run_full(input string tag, input bit pulses);
    int  n_busy = 0, n_rd = 0, n_wr = 0, n_done = 0, spots = 0;
    int  a, b, tw, r, pos;
    bit  e_busy, e_rd, e_wr, wr_prev;
    wr_prev = 1'b0;
`ifdef FFT_CTRL_INV_EN
    inv = pulses;
`endif
    sig = 1'b1;
    tick();
    sig = 1'b0;
`ifdef FFT_CTRL_INV_EN
    inv = 1'b0;
`endif
    for (int c = 1; c <= 130; c++) begin
      pos    = (c - 1) % ROUND_CYC;
      r      = (c - 1) / ROUND_CYC;
      e_busy = (c <= BUSY_CYC);
      e_rd   = e_busy && (pos < ISSUE_CYC);
      e_wr   = e_busy && (pos >= 5);
      n_busy += int'(busy);
      n_rd   += int'(rd_en);
      n_wr   += int'(wr_en);
      n_done += int'(done);
      check({tag, "_busy"},  busy,  e_busy);
      check({tag, "_done"},  done,  (c == BUSY_CYC + 1));
      check({tag, "_rd_en"}, rd_en, e_rd);
      check({tag, "_wr_en"}, wr_en, e_wr);
      check({tag, "_cycle"}, cycle, (c <= BUSY_CYC) ? c - 1 : BUSY_CYC);
      if (e_rd) begin
        ref_addr(r, pos, a, b, tw);
        hist_a[c] = a;
        hist_b[c] = b;
        check({tag, "_rnd"},   rnd,    r);
        check({tag, "_iter"},  iter,   pos);
        check({tag, "_addra"}, addra,  a);
        check({tag, "_addrb"}, addrb,  b);
        check({tag, "_tw"},    tw_idx, tw);
        if (r == 0 && pos == 0) begin
          spots++;
          check({tag, "_r0k0_a"}, addra, 0);
          check({tag, "_r0k0_b"}, addrb, 1);
          check({tag, "_r0k0_tw"}, tw_idx, 0);
        end
        if (r == 0 && pos == 1) begin
          spots++;
          check({tag, "_r0k1_a"}, addra, 2);
          check({tag, "_r0k1_b"}, addrb, 3);
        end
        if (r == 2 && pos == 5) begin
          spots++;
          check({tag, "_r2k5_a"}, addra, 9);
          check({tag, "_r2k5_b"}, addrb, 13);
          check({tag, "_r2k5_tw"}, tw_idx, 4);
        end
        if (r == 4 && pos == 3) begin
          spots++;
          check({tag, "_r4k3_a"}, addra, 3);
          check({tag, "_r4k3_b"}, addrb, 19);
          check({tag, "_r4k3_tw"}, tw_idx, 3);
        end
        if (pos == 0 && r > 0) check({tag, "_raw_gap"}, wr_prev, 1);
      end
      if (e_wr) begin
        check({tag, "_waddra"}, waddra, hist_a[c-5]);
        check({tag, "_waddrb"}, waddrb, hist_b[c-5]);
      end
      if (c > BUSY_CYC + 1) begin
        check({tag, "_rnd_hold"},  rnd,  4);
        check({tag, "_iter_hold"}, iter, 15);
      end
`ifdef FFT_CTRL_INV_EN
      if (e_busy) check({tag, "_tw_conj"}, tw_conj, pulses);
`endif
      wr_prev = wr_en;
      sig = pulses && (c == 30 || c == 60 || c == BUSY_CYC + 1);
      tick();
    end
    sig = 1'b0;
    check({tag, "_n_busy"}, n_busy, BUSY_CYC);
    check({tag, "_n_rd"},   n_rd,   80);
    check({tag, "_n_wr"},   n_wr,   80);
    check({tag, "_n_done"}, n_done, 1);
    check({tag, "_spots"},  spots,  4);
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    sig = 1'b0;
`ifdef FFT_CTRL_INV_EN
    inv = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b0;

    // Idle after reset: everything quiet, counters at zero.
    for (int c = 0; c < 20; c++) begin
      check_quiet("idle");
      check("idle_rnd",   rnd,   0);
      check("idle_iter",  iter,  0);
      check("idle_cycle", cycle, 0);
`ifdef FFT_CTRL_INV_EN
      check("idle_tw_conj", tw_conj, 0);
`endif
      tick();
    end

    // sig coincident with rst: reset wins.
    rst = 1'b1;
    sig = 1'b1;
    tick();
    sig = 1'b0;
    rst = 1'b0;
    check("rst_sig_busy", busy, 0);
    tick();
    check("rst_sig_busy2", busy, 0);
    check("rst_sig_rd", rd_en, 0);

    run_full("run1", 1'b0);

    // Reset during round 2 at k=7.
    sig = 1'b1;
    tick();
    sig = 1'b0;
    found = 1'b0;
    for (int c = 1; c <= 200 && !found; c++) begin
      if (rd_en === 1'b1 && rnd == 2 && iter == 7) found = 1'b1;
      else tick();
    end
    check("midrst_reach", found, 1);
    check("midrst_cycle", cycle, 2 * ROUND_CYC + 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    for (int c = 0; c < 10; c++) begin
      check("midrst_wr_en", wr_en, 0);
      check("midrst_rd_en", rd_en, 0);
      tick();
    end

    run_full("run2", 1'b0);
    run_full("run3", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_ctrl.md
Name: fft_ctrl

Overview:
- Sequencer for the in-place radix-2 DIT FFT over the dual-port data BRAM and one pipelined butterfly unit (fft_op_unit wrapped with OP_LAT register stages).
- On a start pulse it walks all LOGN rounds. Each cycle it issues one butterfly: two read addresses plus a twiddle index.
- It delays the same addresses to produce the write-back, and drains the pipeline between rounds to avoid read-after-write hazards.
- Input data is already bit-reversed at load time by the host path; that is outside this block.

Parameters:
- LOGN, 5, log2 of transform length N (N=32).
- OP_LAT, 4, butterfly pipeline latency in cycles, from BRAM dout valid to result valid.
- CW, 17, width of the rnd/iter/cycle status counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sig  in  1  start pulse, sampled on the rising edge.
- busy  out  1  transform in progress.
- done  out  1  one-cycle pulse when the final write has been issued.
- rnd  out  CW  current round, 0..LOGN-1.
- iter  out  CW  butterfly index k within the round, 0..N/2-1.
- cycle  out  CW  cycles since start; saturates at all-ones.
- rd_en  out  1  read strobe to BRAM ports A and B.
- addra  out  LOGN  read address for operand a.
- addrb  out  LOGN  read address for operand b.
- tw_idx  out  LOGN-1  twiddle ROM index, aligned with addra/addrb.
- wr_en  out  1  write strobe to BRAM ports A and B.
- waddra  out  LOGN  write address for result c.
- waddrb  out  LOGN  write address for result d.

Behaviour:
- Reset: every output is 0, state is IDLE, the write-delay pipe valid bits are cleared, and all counters are 0.
- IDLE:
  - sig=1 moves to ISSUE at the next edge.
  - busy, rnd, iter and cycle are updated at that same edge: busy=1, rnd=0, iter=0, cycle=0.
- ISSUE, one butterfly per cycle:
  - rd_en=1.
  - half = 1<<rnd; grp = iter>>rnd; idx = iter & (half-1).
  - addra = grp*2*half + idx; addrb = addra + half.
  - tw_idx = idx << (LOGN-1-rnd).
  - All address arithmetic is LOGN bits wide with no overflow, because b < N by construction.
  - When iter = N/2-1, go to DRAIN; otherwise iter increments.
- DRAIN:
  - Lasts exactly 1+OP_LAT cycles, with rd_en=0.
  - Then, if rnd = LOGN-1, go to DONE; otherwise rnd increments, iter resets to 0, and the state returns to ISSUE.
- DONE:
  - Lasts one cycle: done=1, busy=0, then IDLE.
  - rnd/iter hold their last values until the next start.
- Write pipe:
  - A shift register of depth 1+OP_LAT carries {valid, addra, addrb}.
  - wr_en/waddra/waddrb equal the issue-time values exactly 1+OP_LAT cycles later.
  - The last write of each round therefore lands in the final DRAIN cycle, so the next round's first read follows the write by one edge.
- cycle increments every cycle while busy=1.
- Boundary conditions:
  - sig while busy or in DONE is ignored, with no restart.
  - sig in the same cycle as rst: rst wins.
  - rst mid-operation forces IDLE and clears the pipe valids, so no spurious wr_en appears after reset.
- Timing, for the LOGN=5, OP_LAT=4 defaults:
  - 16 issue + 5 drain = 21 cycles per round.
  - busy is high for 105 cycles; done is asserted in the 106th cycle after the sig edge.

Optional Feature:
- Macro FFT_CTRL_INV_EN.
- When defined:
  - Adds input port inv (1 bit), sampled with sig.
  - Adds output port tw_conj (1 bit), held at the latched inv value for the whole transform and reset to 0. It drives twiddle conjugation for the inverse FFT.
  - The unscaled result is left to the host.
- When undefined: neither port exists and the butterfly is configured for the forward transform only.
- Sequencing and timing are identical in both builds.

Decomposition:
- Shared package/header holds:
  - logN and the N/2 constant;
  - the state encoding IDLE/ISSUE/DRAIN/DONE;
  - the default OP_LAT.
- One sub-module, fft_addr_gen: the combinational mapping (rnd, iter) -> (addra, addrb, tw_idx), unit-testable on its own.
- The FSM, counters and write-delay pipe stay in fft_ctrl.

Test Plan:
- Reset, then idle for 20 cycles -> all outputs 0; wr_en never asserted.
- sig pulse, LOGN=5, OP_LAT=4 -> busy high for exactly 105 cycles, done for one cycle immediately after, 80 rd_en cycles, 80 wr_en cycles.
- Address checks:
  - Round 0: k=0 -> a=0, b=1, tw=0; k=1 -> a=2, b=3.
  - Round 2: k=5 -> a=9, b=13, tw=4.
  - Round 4: k=3 -> a=3, b=19, tw=3.
- Write alignment: for every issue at cycle t, wr_en=1 at t+5 with the same addresses. The first read of round r+1 occurs one cycle after the last write of round r.
- rst asserted during round 2, issue k=7 -> next cycle: busy=0, no wr_en for the following 10 cycles. A subsequent sig then runs a full 105-cycle transform.
- sig pulses at cycles 30 and 60 of a running transform are ignored, so done still fires once. With FFT_CTRL_INV_EN and inv=1 at start, tw_conj=1 for the whole run.
